// File: rtl/step_ctrl_pkg.sv
// Shared definitions for the debug step controller: state encoding,
// default command codes and the default executed-step counter width.
package step_ctrl_pkg;

    localparam logic [2:0] ST_HALT  = 3'd0;
    localparam logic [2:0] ST_STEP  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_ARG   = 3'd3;
    localparam logic [2:0] ST_MULTI = 3'd4;

    typedef enum logic [2:0] {
        HALT  = ST_HALT,
        STEP  = ST_STEP,
        RUN   = ST_RUN,
        ARG   = ST_ARG,
        MULTI = ST_MULTI
    } state_t;

    localparam logic [7:0] DEF_STEP_CODE  = 8'h73;  // 's'
    localparam logic [7:0] DEF_RUN_CODE   = 8'h63;  // 'c'
    localparam logic [7:0] DEF_HALT_CODE  = 8'h70;  // 'p'
    localparam logic [7:0] DEF_MULTI_CODE = 8'h6E;  // 'n'

    localparam int DEF_CNT_W = 16;

    // States in which the pipeline enable is high.
    function automatic logic is_stepping(input state_t s);
        return (s == STEP) || (s == RUN) || (s == MULTI);
    endfunction

endpackage

// File: rtl/step_down_counter.sv
// Loadable 8-bit down-counter holding the remaining multi-step count.
// 'last' flags the final remaining step (rem == 1). Clear wins over load,
// load wins over decrement; the count never wraps below zero.
module step_down_counter (
    input  logic       clk,
    input  logic       clear,
    input  logic       load,
    input  logic       dec,
    input  logic [7:0] d,
    output logic [7:0] rem,
    output logic       last
);

    // Remaining-count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            rem <= 8'd0;
        end else if (load) begin
            rem <= d;
        end else if (dec && (rem != 8'd0)) begin
            rem <= rem - 8'd1;
        end
    end

    assign last = (rem == 8'd1);

endmodule

// File: rtl/step_ctrl.sv
// Debug step controller: decodes command bytes and drives the pipeline
// enable. Counted multi-step support is built only when the macro
// STEP_MULTI_EN is defined; otherwise the multi-step code is rejected as
// an unrecognised byte and outDone stays low.
//
// state | meaning
// ------+--------------------------------------------------------------
// HALT  | idle, pipeline frozen, waiting for a command
// STEP  | single pipeline advance, lasts one cycle unless re-triggered
// RUN   | free-running until the halt code arrives
// ARG   | multi-step code seen, next accepted byte is the step count
// MULTI | counted run, rem steps left including the current one
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] STEP_CODE  = DATA_W'(DEF_STEP_CODE),
    parameter logic [DATA_W-1:0] RUN_CODE   = DATA_W'(DEF_RUN_CODE),
    parameter logic [DATA_W-1:0] HALT_CODE  = DATA_W'(DEF_HALT_CODE),
    parameter logic [DATA_W-1:0] MULTI_CODE = DATA_W'(DEF_MULTI_CODE),
    parameter int                CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] inDato,
    input  logic              inValid,
    output logic              outStep,
    output logic              outRunning,
    output logic              outDone,
    output logic              outBadCmd,
    output logic [CNT_W-1:0]  outStepCnt
);

    state_t state;
    state_t state_nxt;
    logic   done_nxt;
    logic   bad_nxt;
    logic   is_halt_cmd;

    assign is_halt_cmd = inValid && (inDato == HALT_CODE);

`ifdef STEP_MULTI_EN
    // Count byte is taken from the low bits, zero-extended when narrower than 8.
    localparam int AW = (DATA_W < 8) ? DATA_W : 8;

    logic [7:0] arg_byte;
    logic [7:0] rem;
    logic       rem_last;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_abort;

    assign arg_byte = 8'(inDato[AW-1:0]);

    step_down_counter u_rem (
        .clk   (clk),
        .clear (reset | cnt_abort),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .d     (arg_byte),
        .rem   (rem),
        .last  (rem_last)
    );
`endif

    // Next-state and pulse decode from the current state and accepted byte.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        bad_nxt   = 1'b0;
`ifdef STEP_MULTI_EN
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cnt_abort = 1'b0;
`endif
        case (state)
            HALT, STEP: begin
                state_nxt = HALT;
                if (inValid) begin
                    if (inDato == STEP_CODE) begin
                        state_nxt = STEP;
                    end else if (inDato == RUN_CODE) begin
                        state_nxt = RUN;
`ifdef STEP_MULTI_EN
                    end else if (inDato == MULTI_CODE) begin
                        state_nxt = ARG;
`endif
                    end else if (inDato == HALT_CODE) begin
                        state_nxt = HALT;
                    end else begin
                        bad_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (is_halt_cmd) begin
                    state_nxt = HALT;
                end
            end
`ifdef STEP_MULTI_EN
            ARG: begin
                if (inValid) begin
                    if (arg_byte == 8'd0) begin
                        state_nxt = HALT;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = MULTI;
                        cnt_load  = 1'b1;
                        // A count of one is already the final step.
                        done_nxt  = (arg_byte == 8'd1);
                    end
                end
            end
            MULTI: begin
                if (is_halt_cmd) begin
                    state_nxt = HALT;
                    cnt_abort = 1'b1;
                end else if (rem_last) begin
                    state_nxt = HALT;
                    cnt_dec   = 1'b1;
                end else begin
                    cnt_dec   = 1'b1;
                    // Next cycle holds rem == 1, so done rides with that step.
                    done_nxt  = (rem == 8'd2);
                end
            end
`endif
            default: begin
                state_nxt = HALT;
            end
        endcase
    end

    // State register with registered outputs and the executed-step counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HALT;
            outStep    <= 1'b0;
            outRunning <= 1'b0;
            outDone    <= 1'b0;
            outBadCmd  <= 1'b0;
            outStepCnt <= '0;
        end else begin
            state      <= state_nxt;
            outStep    <= is_stepping(state_nxt);
`ifdef STEP_MULTI_EN
            outRunning <= (state_nxt == RUN) || (state_nxt == MULTI);
`else
            outRunning <= (state_nxt == RUN);
`endif
            outDone    <= done_nxt;
            outBadCmd  <= bad_nxt;
            if (outStep) begin
                outStepCnt <= outStepCnt + 1'b1;
            end
        end
    end

endmodule
